// File: rtl/full_adder_u_half.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder_u_half (with helper submodule half_adder)
//  Description : WIDTH-bit ripple-carry adder. Each bit is a full adder built
//                from two half adders and an OR. It has combinational sum and
//                carry-out outputs, plus copies of both that are registered on
//                the rising clock edge and asynchronously cleared by reset.
//  Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  half_adder : single-bit half adder (sum = a ^ b, carry = a & b)
// ----------------------------------------------------------------------------
module half_adder (
    input  logic i_a,
    input  logic i_b,
    output logic o_sum,
    output logic o_carry
);

    assign o_sum   = i_a ^ i_b;
    assign o_carry = i_a & i_b;

endmodule

// ----------------------------------------------------------------------------
//  full_adder_u_half : ripple chain of half-adder based full-adder cells
// ----------------------------------------------------------------------------
module full_adder_u_half #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic [WIDTH-1:0] S_q,
    output logic             Cout_q
);

    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;

    // Each stage has its own scalar carry-in and carry-out. This keeps the
    // ripple path from feeding back through a single shared vector.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic w_cin;
        logic w_p;
        logic w_g1;
        logic w_g2;
        logic w_cout;

        if (i == 0) begin : g_first
            assign w_cin = Cin;
        end else begin : g_rest
            assign w_cin = g_bit[i-1].w_cout;
        end

        // First half adder: propagate and generate for operand bits
        half_adder u_ha1 (
            .i_a     (A[i]),
            .i_b     (B[i]),
            .o_sum   (w_p),
            .o_carry (w_g1)
        );

        // Second half adder: fold in the incoming carry
        half_adder u_ha2 (
            .i_a     (w_p),
            .i_b     (w_cin),
            .o_sum   (w_sum[i]),
            .o_carry (w_g2)
        );

        assign w_cout = w_g1 | w_g2;
    end : g_bit

    assign w_cout = g_bit[WIDTH-1].w_cout;

    assign S    = w_sum;
    assign Cout = w_cout;

    // Capture the combinational result on every rising edge; clear asynchronously on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s    <= '0;
            r_cout <= 1'b0;
        end else begin
            r_s    <= w_sum;
            r_cout <= w_cout;
        end
    end

    assign S_q    = r_s;
    assign Cout_q = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_full_adder_u_half.sv
`default_nettype none
// ============================================================================
//  Module      : tb_full_adder_u_half
//  Description : Self-checking bench for full_adder_u_half. It builds one
//                WIDTH=1 instance and one WIDTH=8 instance. Expected results
//                are queued when stimulus is driven and are compared when the
//                DUT output is sampled.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_full_adder_u_half;

    logic       clk;
    logic       rst;

    logic       a1, b1, c1;
    logic       s1, co1, sq1, coq1;

    logic [7:0] a8, b8;
    logic       c8;
    logic [7:0] s8, sq8;
    logic       co8, coq8;

    int total;
    int bad;

    typedef struct {
        string       tag;
        logic [63:0] exp;
    } sb_item_t;

    sb_item_t sb[$];

    full_adder_u_half #(.WIDTH(1)) u_dut1 (
        .clk    (clk),
        .rst    (rst),
        .A      (a1),
        .B      (b1),
        .Cin    (c1),
        .S      (s1),
        .Cout   (co1),
        .S_q    (sq1),
        .Cout_q (coq1)
    );

    full_adder_u_half #(.WIDTH(8)) u_dut8 (
        .clk    (clk),
        .rst    (rst),
        .A      (a8),
        .B      (b8),
        .Cin    (c8),
        .S      (s8),
        .Cout   (co8),
        .S_q    (sq8),
        .Cout_q (coq8)
    );

    // Single comparison point: counts every check and reports mismatches
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [63:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.exp = exp;
        sb.push_back(it);
    endtask

    task automatic sb_pop_check(input logic [63:0] got);
        sb_item_t it;
        if (sb.size() == 0) begin
            check("scoreboard_empty", got, ~got);
        end else begin
            it = sb.pop_front();
            check(it.tag, got, it.exp);
        end
    endtask

    // One full clock period. Expected register contents are queued from the
    // inputs the bench drives, then compared just after the rising edge.
    task automatic cycle(input string tag);
        logic [8:0] e8;
        e8 = {1'b0, a8} + {1'b0, b8} + {8'd0, c8};
        #1;
        sb_push({tag, "_w1"}, {62'd0, (a1 & b1) | (a1 & c1) | (b1 & c1), a1 ^ b1 ^ c1});
        sb_push({tag, "_w8"}, {55'd0, e8});
        clk = 1'b1;
        #1;
        sb_pop_check({62'd0, coq1, sq1});
        sb_pop_check({55'd0, coq8, sq8});
        #4 clk = 1'b0;
        #4;
    endtask

    // Spec truth table for {Cout,S}, indexed by {A,B,Cin}
    logic [1:0] tt [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    initial begin
        logic [2:0] v;
        logic [8:0] e8;
        total = 0;
        bad   = 0;
        clk   = 1'b0;
        rst   = 1'b1;
        {a1, b1, c1} = 3'b000;
        a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
        #1;

        // Registered outputs come out of reset cleared
        check("reset_sq1",  {63'd0, sq1},  64'd0);
        check("reset_coq1", {63'd0, coq1}, 64'd0);
        check("reset_sq8",  {56'd0, sq8},  64'd0);
        check("reset_coq8", {63'd0, coq8}, 64'd0);

        // WIDTH=1 exhaustive, no clock running
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            {a1, b1, c1} = v;
            sb_push($sformatf("w1_comb_%0d%0d%0d", v[2], v[1], v[0]), {62'd0, tt[i]});
            #2;
            sb_pop_check({62'd0, co1, s1});
        end

        // Reset held: comb outputs are live, registered outputs are cleared without a clock
        {a1, b1, c1} = 3'b111;
        #2;
        check("rst_comb_w1",  {62'd0, co1, s1},   64'd3);
        check("rst_reg_w1",   {62'd0, coq1, sq1}, 64'd0);
        rst = 1'b0;
        #2;
        check("rst_release_hold_w1", {62'd0, coq1, sq1}, 64'd0);
        cycle("rst_release_load");

        // Registered latency: load 011, change to 000 between edges
        {a1, b1, c1} = 3'b011;
        #2;
        cycle("lat_load_011");
        {a1, b1, c1} = 3'b000;
        #2;
        check("lat_hold_w1", {62'd0, coq1, sq1}, 64'd2);
        cycle("lat_load_000");

        // WIDTH=8 carry ripples through every stage
        a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1;
        #2;
        check("w8_ripple", {55'd0, co8, s8}, 64'h100);

        a8 = 8'hA5; b8 = 8'h5A; c8 = 1'b0;
        #2;
        check("w8_a5_5a_c0", {55'd0, co8, s8}, 64'h0FF);
        c8 = 1'b1;
        #2;
        check("w8_a5_5a_c1", {55'd0, co8, s8}, 64'h100);
        cycle("w8_a5_5a_c1_reg");

        // Random WIDTH=8 vectors, checked combinationally and through the register
        for (int i = 0; i < 12; i++) begin
            a8 = 8'($urandom_range(0, 255));
            b8 = 8'($urandom_range(0, 255));
            c8 = 1'($urandom_range(0, 1));
            {a1, b1, c1} = 3'($urandom_range(0, 7));
            e8 = {1'b0, a8} + {1'b0, b8} + {8'd0, c8};
            sb_push($sformatf("w8_rand_%0d", i), {55'd0, e8});
            #2;
            sb_pop_check({55'd0, co8, s8});
            cycle($sformatf("rand_reg_%0d", i));
        end

        // Asynchronous reset mid-stream while S_q = 8'h3C
        a8 = 8'h3C; b8 = 8'h00; c8 = 1'b0;
        {a1, b1, c1} = 3'b110;
        #2;
        cycle("pre_async_3c");
        check("async_pre_sq8", {56'd0, sq8}, 64'h3C);
        #2;
        rst = 1'b1;
        #1;
        check("async_sq8",  {56'd0, sq8},  64'd0);
        check("async_coq8", {63'd0, coq8}, 64'd0);
        check("async_reg_w1", {62'd0, coq1, sq1}, 64'd0);
        a8 = 8'h10; b8 = 8'h20; c8 = 1'b1;
        #1;
        check("async_comb_w8", {55'd0, co8, s8}, 64'h031);
        a8 = 8'hF0; b8 = 8'h20; c8 = 1'b0;
        #1;
        check("async_comb_w8_cout", {55'd0, co8, s8}, 64'h110);
        // A clock edge while reset is held must not load anything
        clk = 1'b1;
        #1;
        check("async_edge_in_reset", {55'd0, coq8, sq8}, 64'd0);
        #4 clk = 1'b0;
        #4;
        rst = 1'b0;
        #2;
        cycle("post_async_load");

        if (sb.size() != 0) check("scoreboard_leftover", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/full_adder_u_half.md
Name: full_adder_u_half

Overview:
- Full adder built structurally from two half-adder stages plus an OR per bit.
- Generalised to a WIDTH-bit ripple-carry chain; the default WIDTH=1 is the classic 1-bit full adder.
- Sum and carry-out are combinational. A registered copy of both is also provided for clocked consumers.
- Used as the basic arithmetic cell in the lab adder datapaths.

Parameters:
- WIDTH, 1, operand width in bits. Legal range 1..64.

Ports:
- clk  input  1  clock for the registered outputs only
- rst  input  1  asynchronous, active-high reset of the registered outputs
- A  input  WIDTH  addend
- B  input  WIDTH  addend
- Cin  input  1  carry-in to bit 0
- S  output  WIDTH  combinational sum
- Cout  output  1  combinational carry-out of the MSB
- S_q  output  WIDTH  S registered on rising clk
- Cout_q  output  1  Cout registered on rising clk

Interface note:
- One clock; reset is asynchronous and active-high.

Behaviour:
- Per bit i, with carry c[0] = Cin:
  - Half adder 1: p = A[i] xor B[i], g1 = A[i] and B[i].
  - Half adder 2: S[i] = p xor c[i], g2 = p and c[i].
  - c[i+1] = g1 or g2.
- Cout = c[WIDTH].
- Arithmetic: {Cout, S} = A + B + Cin, exact, unsigned, (WIDTH+1) bits. No overflow beyond Cout.
- Half adder is a separate submodule instantiated twice per bit. Ripple chain via generate loop.
- S and Cout: purely combinational.
  - Zero-cycle latency.
  - Independent of clk and rst.
  - Valid whenever inputs are stable; settle within one delta/propagation path.
  - Never X when inputs are known.
- S_q and Cout_q:
  - On rising clk, capture the current S and Cout. Latency is exactly 1 cycle.
  - While rst = 1: S_q = 0, Cout_q = 0, immediately and without waiting for clk.
  - On rst deassertion, the first rising clk loads the current sum.
- Reset mid-operation: registered outputs clear asynchronously; combinational outputs are unaffected.
- Input changes between clock edges: only the value present at the edge is captured. No glitch filtering is required on S/Cout.
- No enables, no handshake, no state machine.

Test Plan:
- WIDTH=1 exhaustive, inputs given as A,B,Cin, 2 time units apart, no clock running; S/Cout checked combinationally:
  - 000 -> S=0, Cout=0
  - 001 -> S=1, Cout=0
  - 010 -> S=1, Cout=0
  - 011 -> S=0, Cout=1
  - 100 -> S=1, Cout=0
  - 101 -> S=0, Cout=1
  - 110 -> S=0, Cout=1
  - 111 -> S=1, Cout=1
- WIDTH=1, rst=1 with A=1, B=1, Cin=1:
  - S=1, Cout=1 combinationally.
  - S_q=0, Cout_q=0 with no clk edge.
  - Release rst, one rising clk -> S_q=1, Cout_q=1.
- WIDTH=1 registered latency: change inputs 011 -> 000 between edges.
  - S_q/Cout_q hold 0/1 until the next rising edge, then become 0/0.
- WIDTH=8, carry ripple through every stage: A=8'hFF, B=8'h00, Cin=1 -> S=8'h00, Cout=1.
- WIDTH=8, sum with carry-out: A=8'hA5, B=8'h5A, Cin=0 -> S=8'hFF, Cout=0; then Cin=1 -> S=8'h00, Cout=1.
- WIDTH=8, asynchronous reset mid-stream: assert rst between clk edges while S_q=8'h3C.
  - S_q=0 and Cout_q=0 immediately.
  - S continues to track A+B+Cin.
